// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM arbiter: CPU port m0 (with lock) and video/DMA port m1 share one controller.
// m1 has priority, but m0 is forced through after STARVE_LIMIT consecutive m1 wins.
module sdram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_rd_i,
  input  logic        m0_wr_i,
  input  logic        m0_lock_i,
  input  logic [23:0] m0_addr_x16_i,
  input  logic [15:0] m0_wdata_i,
  input  logic [1:0]  m0_wmask_i,
  output logic        m0_rdy_o,
  input  logic        m0_ack_i,
  output logic [15:0] m0_rdata_o,
  input  logic        m1_rd_i,
  input  logic        m1_wr_i,
  input  logic [23:0] m1_addr_x16_i,
  input  logic [15:0] m1_wdata_i,
  input  logic [1:0]  m1_wmask_i,
  output logic        m1_rdy_o,
  input  logic        m1_ack_i,
  output logic [15:0] m1_rdata_o,
  output logic        sdram_rd_o,
  output logic        sdram_wr_o,
  output logic [23:0] sdram_addr_x16_o,
  output logic [15:0] sdram_wdata_o,
  output logic [1:0]  sdram_wmask_o,
  input  logic        sdram_rdy_i,
  output logic        sdram_ack_o,
  input  logic [15:0] sdram_rdata_i
);

  typedef enum logic [2:0] {StIdle, StIssue, StBusy, StDone, StAck} state_e;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  wmask_q, wmask_d;
  logic [15:0] rdata_q, rdata_d;

  logic req0, req1, lock_excl, win, win_valid;

  assign req0      = m0_rd_i | m0_wr_i;
  assign req1      = m1_rd_i | m1_wr_i;
  // The lock only binds while m0 holds the grant.
  assign lock_excl = ~gnt_q & m0_lock_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      gnt_q    <= 1'b0;
      starve_q <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 24'd0;
      wdata_q  <= 16'd0;
      wmask_q  <= 2'b11;
      rdata_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    starve_d  = starve_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    win       = 1'b0;
    win_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lock_excl) begin
          win_valid = req0;
        end else if (req0 && req1) begin
          win_valid = 1'b1;
          win       = (starve_q != Limit);
        end else begin
          win_valid = req0 | req1;
          win       = ~req0;
        end
        if (win_valid) begin
          state_d = StIssue;
          gnt_d   = win;
          if (!win) begin
            starve_d = 4'd0;
          end else if (req0) begin
            starve_d = starve_q + 4'd1;
          end
          // Write wins over read when a requester raises both.
          wr_d    = win ? m1_wr_i : m0_wr_i;
          rd_d    = win ? (m1_rd_i & ~m1_wr_i) : (m0_rd_i & ~m0_wr_i);
          addr_d  = win ? m1_addr_x16_i : m0_addr_x16_i;
          wdata_d = win ? m1_wdata_i : m0_wdata_i;
          wmask_d = win ? m1_wmask_i : m0_wmask_i;
        end
      end
      StIssue: begin
        if (!sdram_rdy_i) state_d = StBusy;
      end
      StBusy: begin
        if (sdram_rdy_i) begin
          rdata_d = sdram_rdata_i;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (gnt_q ? m1_ack_i : m0_ack_i) state_d = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    m0_rdy_o         = ~rst_i & ((state_q == StIdle) | ((state_q == StDone) & ~gnt_q));
    m1_rdy_o         = ~rst_i & (((state_q == StIdle) & ~lock_excl) |
                                 ((state_q == StDone) & gnt_q));
    m0_rdata_o       = rdata_q;
    m1_rdata_o       = rdata_q;
    sdram_rd_o       = rd_q;
    sdram_wr_o       = wr_q;
    sdram_addr_x16_o = addr_q;
    sdram_wdata_o    = wdata_q;
    sdram_wmask_o    = wmask_q;
    sdram_ack_o      = (state_q == StAck);
  end

endmodule
